// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with 64-word data memory, MEM/WB register, fault flag and store counter
module mem_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_mem_read,
   input  logic        i_mem_write,
   input  logic        i_mem_to_reg,
   input  logic        i_reg_write,
   input  logic        i_branch,
   input  logic        i_zflag,
   input  logic [31:0] i_alu_result,
   input  logic [31:0] i_read_rb_2,
   input  logic [31:0] i_address_pc,
   input  logic [4:0]  i_write_address,
   input  logic        i_stall,
   output logic        o_pcsrc,
   output logic [31:0] o_branch_target,
   output logic        o_reg_write,
   output logic        o_mem_to_reg,
   output logic [31:0] o_read_data,
   output logic [31:0] o_alu_result,
   output logic [4:0]  o_write_address,
   output logic        o_misaligned,
   output logic [15:0] o_store_count
);
   logic [31:0] mem_q [0:63];
   logic [5:0]  idx;
   logic        misal, wr_en;
   logic        reg_write_q, reg_write_d, mem_to_reg_q, mem_to_reg_d, misaligned_q, misaligned_d;
   logic [31:0] read_data_q, read_data_d, alu_result_q, alu_result_d;
   logic [4:0]  write_address_q, write_address_d;
   logic [15:0] store_count_q, store_count_d;

   assign idx             = i_alu_result[7:2];
   assign misal           = (i_mem_read | i_mem_write) & (|i_alu_result[1:0]);
   assign wr_en           = i_mem_write & ~misal & ~i_stall;
   assign o_pcsrc         = i_branch & i_zflag & ~rst;
   assign o_branch_target = i_address_pc;

   always_comb begin
      reg_write_d     = i_stall ? reg_write_q : i_reg_write & ~(i_mem_read & misal);
      mem_to_reg_d    = i_stall ? mem_to_reg_q : i_mem_to_reg;
      read_data_d     = i_stall ? read_data_q : (i_mem_read & ~misal) ? mem_q[idx] : 32'd0;
      alu_result_d    = i_stall ? alu_result_q : i_alu_result;
      write_address_d = i_stall ? write_address_q : i_write_address;
      misaligned_d    = misaligned_q | (misal & ~i_stall);
      store_count_d   = store_count_q + {15'd0, wr_en};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         reg_write_q     <= 1'b0;
         mem_to_reg_q    <= 1'b0;
         read_data_q     <= 32'd0;
         alu_result_q    <= 32'd0;
         write_address_q <= 5'd0;
         misaligned_q    <= 1'b0;
         store_count_q   <= 16'd0;
         for (int i = 0; i < 64; i++) mem_q[i] <= 32'd0;
      end else begin
         reg_write_q     <= reg_write_d;
         mem_to_reg_q    <= mem_to_reg_d;
         read_data_q     <= read_data_d;
         alu_result_q    <= alu_result_d;
         write_address_q <= write_address_d;
         misaligned_q    <= misaligned_d;
         store_count_q   <= store_count_d;
         if (wr_en) mem_q[idx] <= i_read_rb_2;
      end
   end

   assign o_reg_write     = reg_write_q;
   assign o_mem_to_reg    = mem_to_reg_q;
   assign o_read_data     = read_data_q;
   assign o_alu_result    = alu_result_q;
   assign o_write_address = write_address_q;
   assign o_misaligned    = misaligned_q;
   assign o_store_count   = store_count_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: vector table with scoreboard queue, plus branch and counter-wrap sequences
module tb_mem_stage;
   logic        clk = 1'b0, rst = 1'b1;
   logic        i_mem_read = 1'b0, i_mem_write = 1'b0, i_mem_to_reg = 1'b0, i_reg_write = 1'b0;
   logic        i_branch = 1'b0, i_zflag = 1'b0, i_stall = 1'b0;
   logic [31:0] i_alu_result = '0, i_read_rb_2 = '0, i_address_pc = '0;
   logic [4:0]  i_write_address = '0;
   logic        o_pcsrc, o_reg_write, o_mem_to_reg, o_misaligned;
   logic [31:0] o_branch_target, o_read_data, o_alu_result;
   logic [4:0]  o_write_address;
   logic [15:0] o_store_count;
   int n_vec = 0, n_bad = 0;

   typedef struct {
      logic        rst, rd, wr, m2r, rw, st;
      logic [31:0] addr, wdata;
      logic [4:0]  wa;
      logic [31:0] e_rd;
      logic        e_rw, e_m2r;
      logic [31:0] e_alu;
      logic [4:0]  e_wa;
      logic        e_mis;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t tbl [21];
   vec_t sb [$];
   vec_t e;

   mem_stage dut (
      .clk(clk), .rst(rst), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
      .i_mem_to_reg(i_mem_to_reg), .i_reg_write(i_reg_write), .i_branch(i_branch),
      .i_zflag(i_zflag), .i_alu_result(i_alu_result), .i_read_rb_2(i_read_rb_2),
      .i_address_pc(i_address_pc), .i_write_address(i_write_address), .i_stall(i_stall),
      .o_pcsrc(o_pcsrc), .o_branch_target(o_branch_target), .o_reg_write(o_reg_write),
      .o_mem_to_reg(o_mem_to_reg), .o_read_data(o_read_data), .o_alu_result(o_alu_result),
      .o_write_address(o_write_address), .o_misaligned(o_misaligned), .o_store_count(o_store_count)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input bit r, rd, wr, m2r, rw, st, input logic [31:0] addr, wdata,
                               input logic [4:0] wa, input logic [31:0] erd, input bit erw, em2r,
                               input logic [31:0] ealu, input logic [4:0] ewa, input bit emis,
                               input logic [15:0] ecnt);
      vec_t v;
      v.rst = r; v.rd = rd; v.wr = wr; v.m2r = m2r; v.rw = rw; v.st = st;
      v.addr = addr; v.wdata = wdata; v.wa = wa;
      v.e_rd = erd; v.e_rw = erw; v.e_m2r = em2r; v.e_alu = ealu; v.e_wa = ewa;
      v.e_mis = emis; v.e_cnt = ecnt;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst = v.rst; i_mem_read = v.rd; i_mem_write = v.wr; i_mem_to_reg = v.m2r;
      i_reg_write = v.rw; i_stall = v.st; i_alu_result = v.addr; i_read_rb_2 = v.wdata;
      i_write_address = v.wa;
   endtask

   initial begin
      tbl[0]  = mk(1,0,1,0,1,0, 32'h10, 32'h99, 5'd3,  32'h0, 0,0, 32'h0, 5'd0, 0, 16'd0);
      tbl[1]  = mk(0,0,1,0,0,0, 32'h10, 32'hDEADBEEF, 5'd0, 32'h0, 0,0, 32'h10, 5'd0, 0, 16'd1);
      tbl[2]  = mk(0,1,0,1,1,0, 32'h10, 32'h0, 5'd5, 32'hDEADBEEF, 1,1, 32'h10, 5'd5, 0, 16'd1);
      tbl[3]  = mk(0,0,1,0,0,0, 32'h104, 32'h1234, 5'd0, 32'h0, 0,0, 32'h104, 5'd0, 0, 16'd2);
      tbl[4]  = mk(0,1,0,1,1,0, 32'h4, 32'h0, 5'd7, 32'h1234, 1,1, 32'h4, 5'd7, 0, 16'd2);
      tbl[5]  = mk(0,1,1,0,1,0, 32'h10, 32'hCAFEF00D, 5'd2, 32'hDEADBEEF, 1,0, 32'h10, 5'd2, 0, 16'd3);
      tbl[6]  = mk(0,1,0,0,0,0, 32'h10, 32'h0, 5'd1, 32'hCAFEF00D, 0,0, 32'h10, 5'd1, 0, 16'd3);
      tbl[7]  = mk(0,1,0,1,1,0, 32'h12, 32'h0, 5'd9, 32'h0, 0,1, 32'h12, 5'd9, 1, 16'd3);
      tbl[8]  = mk(0,1,0,1,1,0, 32'h4, 32'h0, 5'd4, 32'h1234, 1,1, 32'h4, 5'd4, 1, 16'd3);
      tbl[9]  = mk(0,0,1,0,1,0, 32'h21, 32'hFFFF, 5'd0, 32'h0, 1,0, 32'h21, 5'd0, 1, 16'd3);
      tbl[10] = mk(0,0,0,0,1,0, 32'hABCD0000, 32'h0, 5'd31, 32'h0, 1,0, 32'hABCD0000, 5'd31, 1, 16'd3);
      for (int i = 11; i < 14; i++)
         tbl[i] = mk(0,0,1,1,1,1, 32'h20, 32'h55, 5'd6, 32'h0, 1,0, 32'hABCD0000, 5'd31, 1, 16'd3);
      tbl[14] = mk(0,1,1,1,1,0, 32'h20, 32'h55, 5'd6, 32'h0, 1,1, 32'h20, 5'd6, 1, 16'd4);
      tbl[15] = mk(0,1,0,0,0,0, 32'h20, 32'h0, 5'd0, 32'h55, 0,0, 32'h20, 5'd0, 1, 16'd4);
      tbl[16] = mk(1,0,1,0,1,1, 32'h20, 32'h77, 5'd3, 32'h0, 0,0, 32'h0, 5'd0, 0, 16'd0);
      tbl[17] = mk(0,1,0,1,1,0, 32'h20, 32'h0, 5'd3, 32'h0, 1,1, 32'h20, 5'd3, 0, 16'd0);
      tbl[18] = mk(0,1,0,1,1,0, 32'h10, 32'h0, 5'd3, 32'h0, 1,1, 32'h10, 5'd3, 0, 16'd0);
      tbl[19] = mk(0,1,0,0,0,1, 32'h13, 32'h0, 5'd8, 32'h0, 1,1, 32'h10, 5'd3, 0, 16'd0);
      tbl[20] = mk(0,0,0,0,1,0, 32'h13, 32'h0, 5'd1, 32'h0, 1,0, 32'h13, 5'd1, 0, 16'd0);

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      i_branch = 1'b1; i_zflag = 1'b1; i_address_pc = 32'h40;
      #1 check("pcsrc_taken", {31'd0, o_pcsrc}, 32'd1);
      check("branch_target", o_branch_target, 32'h40);
      i_zflag = 1'b0;
      #1 check("pcsrc_zflag0", {31'd0, o_pcsrc}, 32'd0);
      i_branch = 1'b0; i_zflag = 1'b1;
      #1 check("pcsrc_branch0", {31'd0, o_pcsrc}, 32'd0);
      i_branch = 1'b1; i_stall = 1'b1;
      #1 check("pcsrc_stalled", {31'd0, o_pcsrc}, 32'd1);
      rst = 1'b1;
      #1 check("pcsrc_in_reset", {31'd0, o_pcsrc}, 32'd0);
      i_branch = 1'b0; i_zflag = 1'b0; i_stall = 1'b0;

      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         drive(tbl[i]);
         sb.push_back(tbl[i]);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         check($sformatf("v%0d read_data", i), o_read_data, e.e_rd);
         check($sformatf("v%0d reg_write", i), {31'd0, o_reg_write}, {31'd0, e.e_rw});
         check($sformatf("v%0d mem_to_reg", i), {31'd0, o_mem_to_reg}, {31'd0, e.e_m2r});
         check($sformatf("v%0d alu_result", i), o_alu_result, e.e_alu);
         check($sformatf("v%0d write_address", i), {27'd0, o_write_address}, {27'd0, e.e_wa});
         check($sformatf("v%0d misaligned", i), {31'd0, o_misaligned}, {31'd0, e.e_mis});
         check($sformatf("v%0d store_count", i), {16'd0, o_store_count}, {16'd0, e.e_cnt});
      end

      @(negedge clk);
      i_mem_read = 1'b0; i_mem_write = 1'b1; i_stall = 1'b0; i_alu_result = 32'h8;
      for (int i = 0; i < 65535; i++) begin
         i_read_rb_2 = i;
         @(negedge clk);
      end
      check("store_count_max", {16'd0, o_store_count}, 32'hFFFF);
      @(negedge clk);
      check("store_count_wrap", {16'd0, o_store_count}, 32'h0);
      i_mem_write = 1'b0; i_mem_read = 1'b1;
      @(negedge clk);
      check("last_store_data", o_read_data, 32'd65534);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
